bob_drain: RTL and testbench

Read-side drain engine for the bob circular buffer. It tracks entries written by the allocator, issues reads to `bob_ram`, and buffers returned data in a small output queue. It presents that data in order to a downstream consumer with a valid/ready handshake and pulses `doRetire` back to `bob_addr` on each accepted entry. It sits between the `bob_ram` read port and the retirement consumer, mirroring the write/allocate path.

---
 rtl/bob_drain_pkg.sv | 16 +
 rtl/bob_drain_fifo.sv | 56 +++++
 rtl/bob_drain.sv | 104 ++++++++++
 tb/tb_bob_drain.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bob_drain_pkg.sv
// Shared bob buffer constants and the pointer incrementer used by the
// allocate and drain paths.
package bob_drain_pkg;

  localparam int BOB_ADDR_WIDTH = 6;
  localparam int BOB_WIDTH      = 16;
  localparam int BOB_COUNT      = 63;
  localparam int BOB_LAST_ADDR  = 62;

  typedef logic [5:0] bob_count_t;

  function automatic logic [15:0] adder_inc(input logic [15:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/bob_drain_fifo.sv
// DEPTH-entry shift FIFO holding returned RAM data; entry 0 is the head
// register, so the head never depends combinationally on wdata.
module bob_drain_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16,
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [CNT_W-1:0] cnt,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] wr_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_nxt = mem;
    wr_idx  = cnt - CNT_W'(pop);
    cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && i == int'(wr_idx)) mem_nxt[i] = wdata;
    end
  end

  // NOTE: the storage is reset here because entry 0 drives out_data, which must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      mem <= mem_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign valid = (cnt != '0);
  assign head  = mem[0];

  overflow_a : assert property (@(posedge clk) disable iff (!rst || flush)
    !(push && !pop && int'(cnt) == DEPTH));

endmodule

// File: rtl/bob_drain.sv
// Read-side drain engine of the bob circular buffer: issues RAM reads for
// written entries and hands them out in order. BOB_DRAIN_SKID_EN selects a
// two-entry output queue (full throughput) instead of a single register.
module bob_drain
  import bob_drain_pkg::*;
#(
  parameter int ADDR_WIDTH = BOB_ADDR_WIDTH,
  parameter int DATA_WIDTH = BOB_WIDTH,
  parameter int LAST_ADDR  = BOB_LAST_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  except,
  input  logic [ADDR_WIDTH-1:0] except_ptr,
  input  logic                  push,
  output logic                  read_clkEn,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  doRetire,
  output logic                  empty
);

`ifdef BOB_DRAIN_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  bob_count_t            pending;
  bob_count_t            pending_nxt;
  logic                  inflight;
  logic [CNT_W-1:0]      buf_cnt;
  logic [CNT_W:0]        occ;
  logic                  pop;
  logic                  issue;

  assign pop = out_valid & out_ready;

  // Slots the queue will hold after this cycle: a read only issues if its
  // data is guaranteed a free entry when it returns.
  assign occ   = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign issue = (pending != '0) && (int'(occ) < DEPTH);

  assign read_clkEn = issue;
  assign read_addr  = rd_ptr;
  assign doRetire   = pop & ~except;
  assign empty      = (pending == '0) && !inflight && (buf_cnt == '0);

  assign ptr_inc = (rd_ptr == ADDR_WIDTH'(LAST_ADDR)) ? '0
                 : ADDR_WIDTH'(adder_inc(16'(rd_ptr)));

  always_comb begin
    pending_nxt = pending;
    case ({push, issue})
      2'b10:   pending_nxt = pending + 6'd1;
      2'b01:   pending_nxt = pending - 6'd1;
      default: pending_nxt = pending;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      pending  <= '0;
      inflight <= 1'b0;
    end else if (except) begin
      rd_ptr   <= except_ptr;
      pending  <= '0;
      inflight <= 1'b0;
    end else begin
      if (issue) rd_ptr <= ptr_inc;
      pending  <= pending_nxt;
      inflight <= issue;
    end
  end

  bob_drain_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (except),
    .push  (inflight),
    .wdata (read_data),
    .pop   (doRetire),
    .cnt   (buf_cnt),
    .valid (out_valid),
    .head  (out_data)
  );

  // The allocator stalls at LAST_ADDR outstanding entries, so this never fires.
  pending_overflow_a : assert property (@(posedge clk) disable iff (!rst || except)
    !(push && pending == 6'(LAST_ADDR)));

endmodule

// File: tb/tb_bob_drain.sv
// Directed bench for bob_drain with a one-cycle-latency RAM model; expected
// cadence follows the build's output queue depth.
module tb_bob_drain;

`ifdef BOB_DRAIN_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int STRIDE = 3 - DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        except = 1'b0;
  logic [5:0]  except_ptr = '0;
  logic        push = 1'b0;
  logic        read_clkEn;
  logic [5:0]  read_addr;
  logic [15:0] read_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        doRetire;
  logic        empty;

  int total = 0;
  int bad   = 0;

  bob_drain dut (
    .clk        (clk),
    .rst        (rst),
    .except     (except),
    .except_ptr (except_ptr),
    .push       (push),
    .read_clkEn (read_clkEn),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .doRetire   (doRetire),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input int a);
    return 16'h5A00 + 16'(a);
  endfunction

  always @(posedge clk) if (read_clkEn) read_data <= data_of(int'(read_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge, return at mid-cycle.
  task automatic cyc(input logic rn, input logic p, input logic r, input logic e, input logic [5:0] ep);
    @(posedge clk);
    #1;
    rst = rn; push = p; out_ready = r; except = e; except_ptr = ep;
    #4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int retire_cnt, reads, last_c, k, idx;
    logic exp_v;
    int addr_q[$];
    logic [15:0] data_q[$];

    // Reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rden", 32'(read_clkEn), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_retire", 32'(doRetire), 0);
    chk("rst_addr", 32'(read_addr), 0);

    // Five pushes on cycles 1..5 with the consumer always ready
    retire_cnt = 0;
    last_c = 4 + 4 * STRIDE + 1;
    for (int c = 1; c <= last_c; c++) begin
      cyc(1, c <= 5, 1, 0, 0);
      k = c - 4;
      exp_v = (k >= 0) && (k % STRIDE == 0) && (k / STRIDE < 5);
      chk($sformatf("burst_valid_c%0d", c), 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        idx = k / STRIDE;
        chk($sformatf("burst_data_c%0d", c), 32'(out_data), 32'(data_of(idx)));
        chk($sformatf("burst_retire_c%0d", c), 32'(doRetire), 1);
      end
      if (c == 2) begin
        chk("burst_rden_c2", 32'(read_clkEn), 1);
        chk("burst_addr_c2", 32'(read_addr), 0);
      end
      if (doRetire) retire_cnt++;
    end
    chk("burst_retire_cnt", 32'(retire_cnt), 5);
    chk("burst_empty_end", 32'(empty), 1);

    // Wrap-around from slot 60
    cyc(1, 0, 1, 1, 6'd60);
    for (int i = 0; i < 34; i++) begin
      cyc(1, i < 4, 1, 0, 0);
      if (read_clkEn) addr_q.push_back(int'(read_addr));
      if (doRetire) data_q.push_back(out_data);
    end
    chk("wrap_reads", 32'(addr_q.size()), 4);
    chk("wrap_pops", 32'(data_q.size()), 4);
    begin
      int exp_a[4] = '{60, 61, 62, 0};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wrap_addr%0d", i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF, 32'(exp_a[i]));
        chk($sformatf("wrap_data%0d", i), (i < data_q.size()) ? 32'(data_q[i]) : 32'hFFFF_FFFF, 32'(data_of(exp_a[i])));
      end
    end

    // Backpressure: three pushes, consumer stalled; read pointer is at 1
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, i < 3, 0, 0, 0);
      if (read_clkEn) reads++;
      if (i >= 3) begin
        chk($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
        chk($sformatf("bp_hold%0d", i), 32'(out_data), 32'(data_of(1)));
        chk($sformatf("bp_retire%0d", i), 32'(doRetire), 0);
      end
    end
    chk("bp_reads", 32'(reads), 32'(DEPTH));
    chk("bp_pending", 32'(dut.pending), 32'(3 - DEPTH));
    data_q.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1, 0, 0);
      if (doRetire) data_q.push_back(out_data);
    end
    chk("bp_pops", 32'(data_q.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order%0d", i), (i < data_q.size()) ? 32'(data_q[i]) : 32'hFFFF_FFFF, 32'(data_of(i + 1)));
    chk("bp_empty", 32'(empty), 1);

    // Flush with buffered and pending entries, then restart at slot 17
    for (int i = 0; i < 8; i++) cyc(1, i < 3, 0, 0, 0);
    chk("exc_pre_valid", 32'(out_valid), 1);
    cyc(1, 0, 1, 1, 6'd17);
    chk("exc_retire_same", 32'(doRetire), 0);
    cyc(1, 0, 1, 0, 0);
    chk("exc_valid", 32'(out_valid), 0);
    chk("exc_empty", 32'(empty), 1);
    chk("exc_retire", 32'(doRetire), 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("exc_rden", 32'(read_clkEn), 1);
    chk("exc_addr", 32'(read_addr), 17);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("exc_out_valid", 32'(out_valid), 1);
    chk("exc_out_data", 32'(out_data), 32'(data_of(17)));
    chk("exc_out_retire", 32'(doRetire), 1);
    cyc(1, 0, 1, 0, 0);
    chk("exc_drained", 32'(empty), 1);

    // Push in the flush cycle is dropped
    cyc(1, 1, 1, 1, 6'd5);
    cyc(1, 0, 1, 0, 0);
    chk("excpush_pending", 32'(dut.pending), 0);
    chk("excpush_rden", 32'(read_clkEn), 0);
    chk("excpush_empty", 32'(empty), 1);
    chk("excpush_addr", 32'(read_addr), 5);

    // Reset mid-stream while the head is valid
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("mrst_pre_valid", 32'(out_valid), 1);
    chk("mrst_pre_data", 32'(out_data), 32'(data_of(5)));
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_retire", 32'(doRetire), 0);
    chk("mrst_rden", 32'(read_clkEn), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_addr", 32'(read_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
